// File: rtl/beep_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : beep_sequencer                                             |
// | Description : Plays N tone bursts on a buzzer pin by driving a one-shot  |
// |               timer. Each on-interval and off-interval is programmed     |
// |               into timetogo, armed with a one-cycle countAct pulse, and  |
// |               completed when the timer raises fullflag.                  |
// | Ports       : clk, rst             clock, synchronous active-high reset  |
// |               start, stop          request / abort                       |
// |               beep_count, on_time, off_time   sequence settings          |
// |               busy, done, buzzer   status and tone output                |
// |               timetogo, countMode, countAct, fullflag   timer interface  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module beep_sequencer #(
    parameter int TW        = 32,
    parameter int NW        = 4,
    parameter int TONE_HALF = 25000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [NW-1:0] beep_count,
    input  logic [TW-1:0] on_time,
    input  logic [TW-1:0] off_time,
    output logic          busy,
    output logic          done,
    output logic          buzzer,
    output logic [TW-1:0] timetogo,
    output logic          countMode,
    output logic          countAct,
    input  logic          fullflag
);

    localparam int            CW          = $clog2(TONE_HALF + 1);
    localparam logic [CW-1:0] c_TONE_LAST = CW'(TONE_HALF - 1);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_ARM_ON   = 3'd1;
    localparam logic [2:0] c_ST_WAIT_ON  = 3'd2;
    localparam logic [2:0] c_ST_ARM_OFF  = 3'd3;
    localparam logic [2:0] c_ST_WAIT_OFF = 3'd4;
    localparam logic [2:0] c_ST_ABORT    = 3'd5;
    localparam logic [2:0] c_ST_DONE     = 3'd6;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [NW-1:0] r_remaining;
    logic [TW-1:0] r_t_on;
    logic [TW-1:0] r_t_off;
    logic [CW-1:0] r_tone_cnt;
    logic [CW-1:0] w_tone_nxt;
    logic          r_buzzer;
    logic          w_buzzer_nxt;
    logic          r_count_act;
    logic          w_count_act_nxt;
    logic [TW-1:0] r_timetogo;
    logic [TW-1:0] w_timetogo_nxt;
    logic          w_accept;
    logic [TW-1:0] w_on_clamped;
    logic [TW-1:0] w_off_clamped;

    // A zero interval would leave fullflag permanently high while the timer
    // idles, so intervals are clamped to at least one tick.
    assign w_on_clamped  = (on_time  == '0) ? TW'(1) : on_time;
    assign w_off_clamped = (off_time == '0) ? TW'(1) : off_time;
    assign w_accept      = (r_state == c_ST_IDLE) && start && (beep_count != '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; stop outranks fullflag-driven progress
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) w_state_nxt = c_ST_ARM_ON;
            end
            c_ST_ARM_ON: begin
                w_state_nxt = stop ? c_ST_ABORT : c_ST_WAIT_ON;
            end
            c_ST_WAIT_ON: begin
                // stop together with fullflag: the timer is already idle, so
                // there is nothing to drain
                if (stop && fullflag)     w_state_nxt = c_ST_IDLE;
                else if (stop)            w_state_nxt = c_ST_ABORT;
                else if (fullflag)        w_state_nxt = (r_remaining == NW'(1)) ? c_ST_DONE
                                                                                : c_ST_ARM_OFF;
            end
            c_ST_ARM_OFF: begin
                w_state_nxt = stop ? c_ST_ABORT : c_ST_WAIT_OFF;
            end
            c_ST_WAIT_OFF: begin
                if (stop && fullflag)     w_state_nxt = c_ST_IDLE;
                else if (stop)            w_state_nxt = c_ST_ABORT;
                else if (fullflag)        w_state_nxt = c_ST_ARM_ON;
            end
            c_ST_ABORT: begin
                // Let the running one-shot finish; a re-arm mid-count would be lost
                if (fullflag) w_state_nxt = c_ST_IDLE;
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Output logic: status decodes plus next values of the registered outputs
    always_comb begin
        busy      = (r_state != c_ST_IDLE);
        done      = (r_state == c_ST_DONE);
        countMode = 1'b0;

        // Arm pulse and interval are loaded on the edge that enters ARM_*, so
        // both are valid during the ARM cycle and timetogo holds until the next arm.
        w_count_act_nxt = (w_state_nxt == c_ST_ARM_ON) || (w_state_nxt == c_ST_ARM_OFF);
        w_timetogo_nxt  = r_timetogo;
        if (w_state_nxt == c_ST_ARM_ON) begin
            w_timetogo_nxt = (r_state == c_ST_IDLE) ? w_on_clamped : r_t_on;
        end else if (w_state_nxt == c_ST_ARM_OFF) begin
            w_timetogo_nxt = r_t_off;
        end

        // Tone generation; a stop silences the buzzer on the very next edge
        w_buzzer_nxt = 1'b0;
        w_tone_nxt   = r_tone_cnt;
        case (r_state)
            c_ST_ARM_ON: begin
                if (!stop) begin
                    w_buzzer_nxt = 1'b1;
                    w_tone_nxt   = '0;
                end
            end
            c_ST_WAIT_ON: begin
                if (!stop) begin
                    if (r_tone_cnt == c_TONE_LAST) begin
                        w_buzzer_nxt = ~r_buzzer;
                        w_tone_nxt   = '0;
                    end else begin
                        w_buzzer_nxt = r_buzzer;
                        w_tone_nxt   = r_tone_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_buzzer_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
            r_t_on      <= TW'(1);
            r_t_off     <= TW'(1);
            r_tone_cnt  <= '0;
            r_buzzer    <= 1'b0;
            r_count_act <= 1'b0;
            r_timetogo  <= TW'(1);
        end else begin
            if (w_accept) begin
                r_remaining <= beep_count;
                r_t_on      <= w_on_clamped;
                r_t_off     <= w_off_clamped;
            end else if ((r_state == c_ST_WAIT_ON) && fullflag && !stop) begin
                r_remaining <= r_remaining - NW'(1);
            end
            r_tone_cnt  <= w_tone_nxt;
            r_buzzer    <= w_buzzer_nxt;
            r_count_act <= w_count_act_nxt;
            r_timetogo  <= w_timetogo_nxt;
        end
    end

    assign buzzer   = r_buzzer;
    assign countAct = r_count_act;
    assign timetogo = r_timetogo;

endmodule
`default_nettype wire

// File: tb/tb_beep_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_beep_sequencer                                          |
// | Description : Self-checking bench for beep_sequencer with a behavioural  |
// |               one-shot timer and a waveform-level reference model.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_beep_sequencer;

    localparam int TW        = 32;
    localparam int NW        = 4;
    localparam int TONE_HALF = 1;

    typedef logic [36:0] obs_t;   // {busy, done, countAct, buzzer, countMode, timetogo}

    typedef struct {
        int nb;
        int on_t;
        int off_t;
        bit noise;
        int exp_acts;
        int exp_busy;
        int exp_ones;
        int exp_done;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [NW-1:0] beep_count;
    logic [TW-1:0] on_time;
    logic [TW-1:0] off_time;
    logic          busy;
    logic          done;
    logic          buzzer;
    logic [TW-1:0] timetogo;
    logic          countMode;
    logic          countAct;
    logic          fullflag;

    int            total = 0;
    int            bad   = 0;
    logic [31:0]   model_tt;
    obs_t          obs;
    vec_t          tbl [6];

    always #5 clk = ~clk;

    beep_sequencer #(
        .TW        (TW),
        .NW        (NW),
        .TONE_HALF (TONE_HALF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .beep_count (beep_count),
        .on_time    (on_time),
        .off_time   (off_time),
        .busy       (busy),
        .done       (done),
        .buzzer     (buzzer),
        .timetogo   (timetogo),
        .countMode  (countMode),
        .countAct   (countAct),
        .fullflag   (fullflag)
    );

    assign obs = {busy, done, countAct, buzzer, countMode, timetogo};

    // Behavioural one-shot timer: active-low reset from the shared net
    logic          tmr_rst_n;
    logic [TW-1:0] tmr_cnt;
    logic          tmr_run;
    assign tmr_rst_n = ~rst;
    always_ff @(posedge clk) begin
        if (!tmr_rst_n) begin
            tmr_cnt <= '0;
            tmr_run <= 1'b0;
        end else if (countAct) begin
            tmr_cnt <= '0;
            tmr_run <= 1'b1;
        end else if (tmr_run) begin
            if (tmr_cnt == timetogo) begin
                tmr_run <= 1'b0;
                tmr_cnt <= '0;
            end else begin
                tmr_cnt <= tmr_cnt + 1;
            end
        end
    end
    assign fullflag = (tmr_cnt == timetogo);

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic obs_t mk(input logic b, input logic d, input logic a, input logic z, input logic [31:0] tt);
        return {b, d, a, z, 1'b0, tt};
    endfunction

    // Expected outputs n cycles after the cycle in which start is presented.
    // Burst k is armed at cycle 1+k*P with P = Ton+Toff+4; the buzzer window
    // of each burst is Ton+2 cycles, delayed one cycle from its arm cycle.
    function automatic obs_t exp_at(input int n, input int nb, input int ton, input int toff,
                                    input logic [31:0] prev_tt);
        int p, d, rel, m;
        logic b, dn, a, bz;
        logic [31:0] tt;
        b = 1'b0; dn = 1'b0; a = 1'b0; bz = 1'b0; tt = prev_tt;
        if (nb == 0 || n <= 0) return mk(b, dn, a, bz, tt);
        p = ton + toff + 4;
        d = 1 + (nb - 1) * p + ton + 2;
        if (n > d) return mk(1'b0, 1'b0, 1'b0, 1'b0, 32'(ton));
        b  = 1'b1;
        dn = (n == d);
        if (n < d) begin
            rel = (n - 1) % p;
            a   = (rel == 0) || (rel == ton + 2);
            tt  = (rel <= ton + 1) ? 32'(ton) : 32'(toff);
        end else begin
            tt = 32'(ton);
        end
        if (n >= 2) begin
            m = n - 2;
            if ((m / p) < nb && (m % p) <= ton + 1) bz = (((m % p) / TONE_HALF) % 2) == 0;
        end
        return mk(b, dn, a, bz, tt);
    endfunction

    task automatic run_seq(input int nb, input int on_t, input int off_t, input bit noise, input string tag,
                           output int acts, output int busy_cyc, output int ones, output int dones);
        int ton, toff, p, d;
        ton  = (on_t  == 0) ? 1 : on_t;
        toff = (off_t == 0) ? 1 : off_t;
        p    = ton + toff + 4;
        d    = (nb == 0) ? 0 : 1 + (nb - 1) * p + ton + 2;
        acts = 0; busy_cyc = 0; ones = 0; dones = 0;
        for (int n = 0; n <= d + 3; n++) begin
            @(negedge clk);
            chk(tag, n, 64'(obs), 64'(exp_at(n, nb, ton, toff, model_tt)));
            acts     += int'(countAct);
            busy_cyc += int'(busy);
            ones     += int'(buzzer);
            dones    += int'(done);
            if (n == 0) begin
                start      = 1'b1;
                beep_count = NW'(nb);
                on_time    = TW'(on_t);
                off_time   = TW'(off_t);
            end else if (noise && n <= d) begin
                start      = 1'($urandom % 2);
                beep_count = NW'($urandom);
                on_time    = TW'($urandom_range(0, 8));
                off_time   = TW'($urandom_range(0, 8));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (nb != 0) model_tt = 32'(ton);
    endtask

    initial begin
        int acts, busy_cyc, ones, dones;
        int nb, on_t, off_t;
        bit noise;

        tbl[0] = '{nb: 1,  on_t: 4, off_t: 0, noise: 1'b0, exp_acts: 1,  exp_busy: 7,  exp_ones: 3,  exp_done: 1};
        tbl[1] = '{nb: 3,  on_t: 5, off_t: 2, noise: 1'b0, exp_acts: 5,  exp_busy: 30, exp_ones: 12, exp_done: 1};
        tbl[2] = '{nb: 2,  on_t: 0, off_t: 0, noise: 1'b0, exp_acts: 3,  exp_busy: 10, exp_ones: 4,  exp_done: 1};
        tbl[3] = '{nb: 0,  on_t: 7, off_t: 7, noise: 1'b0, exp_acts: 0,  exp_busy: 0,  exp_ones: 0,  exp_done: 0};
        tbl[4] = '{nb: 2,  on_t: 3, off_t: 1, noise: 1'b1, exp_acts: 3,  exp_busy: 14, exp_ones: 6,  exp_done: 1};
        tbl[5] = '{nb: 15, on_t: 1, off_t: 1, noise: 1'b0, exp_acts: 29, exp_busy: 88, exp_ones: 30, exp_done: 1};

        rst = 1'b1; start = 1'b0; stop = 1'b0;
        beep_count = '0; on_time = '0; off_time = '0;
        model_tt = 32'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 0, 64'(obs), 64'(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd1)));
        rst = 1'b0;

        // Table-driven sequences
        for (int i = 0; i < 6; i++) begin
            run_seq(tbl[i].nb, tbl[i].on_t, tbl[i].off_t, tbl[i].noise, "tbl_cycle",
                    acts, busy_cyc, ones, dones);
            chk("tbl_countact_pulses", i, 64'(acts),     64'(tbl[i].exp_acts));
            chk("tbl_busy_cycles",     i, 64'(busy_cyc), 64'(tbl[i].exp_busy));
            chk("tbl_buzzer_high",     i, 64'(ones),     64'(tbl[i].exp_ones));
            chk("tbl_done_pulses",     i, 64'(dones),    64'(tbl[i].exp_done));
        end

        // stop two cycles into WAIT_ON: buzzer silenced, busy until the timer drains
        for (int n = 0; n <= 16; n++) begin
            @(negedge clk);
            chk("stop_wait_on", n, 64'(obs),
                64'(mk(n >= 1 && n <= 12, 1'b0, n == 1, n == 2, (n >= 1) ? 32'd10 : model_tt)));
            start = (n == 0);
            stop  = (n == 3);
            if (n == 0) begin
                beep_count = NW'(2); on_time = TW'(10); off_time = TW'(3);
            end
        end
        model_tt = 32'd10;
        run_seq(1, 4, 0, 1'b0, "after_stop", acts, busy_cyc, ones, dones);
        chk("after_stop_done", 0, 64'(dones), 64'd1);

        // stop coinciding with fullflag: straight back to IDLE
        for (int n = 0; n <= 9; n++) begin
            @(negedge clk);
            chk("stop_on_fullflag", n, 64'(obs),
                64'(mk(n >= 1 && n <= 5, 1'b0, n == 1, n == 2 || n == 4, (n >= 1) ? 32'd3 : model_tt)));
            start = (n == 0);
            stop  = (n == 5);
            if (n == 0) begin
                beep_count = NW'(2); on_time = TW'(3); off_time = TW'(3);
            end
        end
        model_tt = 32'd3;

        // rst asserted during WAIT_OFF
        for (int n = 0; n <= 10; n++) begin
            @(negedge clk);
            if (n <= 7)
                chk("rst_wait_off", n, 64'(obs),
                    64'(mk(n >= 1, 1'b0, n == 1 || n == 5, n == 2 || n == 4,
                           (n == 0) ? model_tt : ((n <= 4) ? 32'd2 : 32'd5))));
            else
                chk("rst_wait_off", n, 64'(obs), 64'(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd1)));
            start = (n == 0);
            rst   = (n == 7);
            if (n == 0) begin
                beep_count = NW'(2); on_time = TW'(2); off_time = TW'(5);
            end
        end
        model_tt = 32'd1;
        run_seq(1, 4, 0, 1'b0, "after_rst", acts, busy_cyc, ones, dones);
        chk("after_rst_acts", 0, 64'(acts), 64'd1);

        // Randomised sequences against the waveform model
        for (int i = 0; i < 25; i++) begin
            nb    = int'($urandom_range(0, 5));
            on_t  = int'($urandom_range(0, 6));
            off_t = int'($urandom_range(0, 6));
            noise = 1'($urandom % 2);
            run_seq(nb, on_t, off_t, noise, "rnd_cycle", acts, busy_cyc, ones, dones);
            chk("rnd_countact_pulses", i, 64'(acts),  64'((nb == 0) ? 0 : 2 * nb - 1));
            chk("rnd_done_pulses",     i, 64'(dones), 64'((nb == 0) ? 0 : 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
